color_sense: RTL and testbench
==============================

Name: color_sense

Overview:
- Upstream stage of the core FSM. Drives a TCS3200-style colour sensor and counts its frequency output through the red, blue, green and clear filters in turn.
- Classifies each measurement frame into the 2-bit colour code the core consumes: 0 none, 1 red, 2 green, 3 blue.
- Also produces the colour stability count (color_cnt) that the core's READY state tests.
- One instance serves the object sensor and one serves the station sensor.

Parameters:
- GATE_CYC, 50000, gate window per channel in clk cycles (1 ms at 50 MHz).
- SETTLE_CYC, 5000, ignore window after each filter change, in clk cycles.
- CNT_W, 16, width of each channel edge counter; counters saturate.
- CLEAR_MIN, 20, minimum clear-channel count for an object to be considered present.
- MARGIN, 4, minimum lead of the largest RGB count over the second largest.

Ports:
- clk  in  1  50 MHz crystal clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  measurement enable; low aborts and idles the sequencer.
- sensor_out  in  1  asynchronous square wave from the sensor.
- s2  out  1  filter select S2.
- s3  out  1  filter select S3.
- color  out  2  last classified colour: 0 none, 1 red, 2 green, 3 blue.
- color_valid  out  1  one-cycle pulse when color is updated.
- color_cnt  out  2  consecutive-identical-result count, saturating at 3.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values: s2=0, s3=0, color=0, color_valid=0, color_cnt=0, busy=0. Reset also clears all counters, the timer and the channel index, and puts the FSM in IDLE. Reset mid-frame discards the partial frame; no color_valid is produced.
- sensor_out input path: 2-FF synchroniser, then a rising-edge detector on the synchronised signal.
- Channel order and filter selects {s2,s3}: 0 red=00, 1 blue=01, 2 green=11, 3 clear=10. s2/s3 change on the clock edge that enters SETTLE for a new channel.
- FSM states: IDLE, SETTLE, GATE, CLASSIFY.
  - IDLE: when en=1, go to SETTLE with ch=0 and all four counters cleared. busy=0 only in IDLE.
  - SETTLE: lasts exactly SETTLE_CYC cycles, then GATE. Edges in SETTLE are ignored.
  - GATE: lasts exactly GATE_CYC cycles; each detected edge increments cnt[ch], holding at 2^CNT_W-1.
    - An edge detected in the last GATE cycle counts.
    - At the end of GATE: if ch<3, increment ch and go to SETTLE; if ch==3, go to CLASSIFY.
  - CLASSIFY: lasts one cycle. On the edge leaving it, color, color_cnt and color_valid=1 update together. Next state is SETTLE with ch=0 and counters cleared, so frames run back-to-back while en=1.
- Classification:
  - If c < CLEAR_MIN, result is 0.
  - Otherwise let m = max(r,g,b) and n = second largest. The result is the channel holding m only if m > n and m - n >= MARGIN; otherwise 0. Any tie on the maximum therefore gives 0.
  - Compares are unsigned at CNT_W+1 bits, so there is no wrap.
- color_cnt update on each classification:
  - Result differs from the held color, or this is the first result since reset: color_cnt=1.
  - Otherwise: color_cnt = min(color_cnt+1, 3).
- Frame latency: 4*(SETTLE_CYC+GATE_CYC)+1 cycles from leaving IDLE to the color_valid pulse.
- en=0 in any state: next cycle IDLE, s2=s3=0, counters cleared, no color_valid. color and color_cnt hold.
- en re-asserted: a full new frame starts at ch=0.

Decomposition:
- Shared package color_pkg:
  - Colour codes COL_NONE=0, COL_RED=1, COL_GREEN=2, COL_BLUE=3, shared with the core and the display.
  - Filter select constants FS_RED, FS_BLUE, FS_GREEN, FS_CLEAR.
  - FSM state encoding.
- Sub-module freq_gate_counter: synchroniser, edge detect and gated saturating counter with clear and gate inputs. color_sense holds four count registers, loaded from it per channel.

Test Plan (sim parameters GATE_CYC=100, SETTLE_CYC=10, CNT_W=8, CLEAR_MIN=20, MARGIN=4):
- en=1; inject 40/10/10/60 edges in the R/B/G/C gates -> color_valid exactly 441 cycles after en, color=1, color_cnt=1. Check {s2,s3} sequence 00, 01, 11, 10.
- Same stimulus for 3 more frames -> color=1 each frame, color_cnt 2, 3, 3. Then R=10, G=40 -> color=2, color_cnt=1.
- Clear channel 19 edges with B=50 -> color=0. Clear channel 20 edges -> color=3.
- R=30, G=27, B=5, C=60 -> color=0 (lead 3 < MARGIN). R=30, G=26 -> color=1. R=G=30 -> color=0.
- Toggle sensor_out every cycle during SETTLE only -> all counts 0, color=0. With CNT_W=4, 50 edges in a gate -> count saturates at 15, no wrap.
- Drop en mid-GATE of the green channel, and assert rst mid-frame in a separate run -> no color_valid, s2=s3=0 next cycle. After en/rst release, a full 441-cycle frame precedes the next valid pulse.

Source files
------------

// File: rtl/color_pkg.sv
package color_pkg;

  localparam logic [1:0] COL_NONE  = 2'd0;
  localparam logic [1:0] COL_RED   = 2'd1;
  localparam logic [1:0] COL_GREEN = 2'd2;
  localparam logic [1:0] COL_BLUE  = 2'd3;

  // Filter selects as {s2, s3}
  localparam logic [1:0] FS_RED   = 2'b00;
  localparam logic [1:0] FS_BLUE  = 2'b01;
  localparam logic [1:0] FS_GREEN = 2'b11;
  localparam logic [1:0] FS_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_CLASSIFY
  } cs_state_t;

  // Channel order: 0 red, 1 blue, 2 green, 3 clear
  function automatic logic [1:0] filter_sel(input logic [1:0] ch);
    case (ch)
      2'd0:    return FS_RED;
      2'd1:    return FS_BLUE;
      2'd2:    return FS_GREEN;
      default: return FS_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/color_sense_freq_gate_counter.sv
module freq_gate_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             clear,
  input  logic             gate,
  output logic [CNT_W-1:0] count
);

  logic [1:0]       sync;
  logic             prev;
  logic             edge_det;
  logic [CNT_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
      acc  <= '0;
    end else begin
      sync <= {sync[0], sig};
      prev <= sync[1];
      if (clear) acc <= '0;
      else       acc <= count;
    end
  end

  assign edge_det = sync[1] & ~prev;

  // count already includes an edge seen this cycle, so a caller sampling it on
  // the last gate cycle gets the full total.
  always_comb begin
    count = acc;
    if (gate && edge_det && (acc != '1)) count = acc + 1'b1;
  end

endmodule

// File: rtl/color_sense.sv
module color_sense
  import color_pkg::*;
#(
  parameter int unsigned GATE_CYC   = 50000,
  parameter int unsigned SETTLE_CYC = 5000,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned CLEAR_MIN  = 20,
  parameter int unsigned MARGIN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sensor_out,
  output logic       s2,
  output logic       s3,
  output logic [1:0] color,
  output logic       color_valid,
  output logic [1:0] color_cnt,
  output logic       busy
);

  localparam int unsigned TMR_MAX = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYC - 1);
  localparam int unsigned CW = CNT_W + 1;

  cs_state_t        state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic             timer_done;
  logic [1:0]       ch;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] live_cnt;
  logic             gate_on;
  logic             have_result;

  logic [CW-1:0] r, g, b, c, m, n;
  logic [1:0]    mcol, result;

  assign timer_done = (timer == '0);
  assign gate_on    = (state == ST_GATE);
  assign busy       = (state != ST_IDLE);

  freq_gate_counter #(
    .CNT_W(CNT_W)
  ) u_fgc (
    .clk  (clk),
    .rst  (rst),
    .sig  (sensor_out),
    .clear(!gate_on),
    .gate (gate_on),
    .count(live_cnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (en) state_nxt = ST_SETTLE;
      ST_SETTLE:   if (timer_done) state_nxt = ST_GATE;
      ST_GATE:     if (timer_done) state_nxt = (ch == 2'd3) ? ST_CLASSIFY : ST_SETTLE;
      ST_CLASSIFY: state_nxt = ST_SETTLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (!en) state_nxt = ST_IDLE;
  end

  always_comb begin
    r = {1'b0, cnt_q[0]};
    b = {1'b0, cnt_q[1]};
    g = {1'b0, cnt_q[2]};
    c = {1'b0, cnt_q[3]};
    if (r >= g && r >= b) begin
      m    = r;
      mcol = COL_RED;
      n    = (g >= b) ? g : b;
    end else if (g >= b) begin
      m    = g;
      mcol = COL_GREEN;
      n    = (r >= b) ? r : b;
    end else begin
      m    = b;
      mcol = COL_BLUE;
      n    = (r >= g) ? r : g;
    end
    result = COL_NONE;
    if ((c >= CW'(CLEAR_MIN)) && (m > n) && ((m - n) >= CW'(MARGIN))) result = mcol;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      ch          <= '0;
      cnt_q       <= '{default: '0};
      {s2, s3}    <= '0;
      color       <= COL_NONE;
      color_cnt   <= '0;
      color_valid <= 1'b0;
      have_result <= 1'b0;
    end else begin
      state       <= state_nxt;
      color_valid <= 1'b0;
      if (!en) begin
        timer    <= '0;
        ch       <= '0;
        cnt_q    <= '{default: '0};
        {s2, s3} <= FS_RED;
      end else begin
        case (state)
          ST_IDLE, ST_CLASSIFY: begin
            timer    <= SETTLE_LD;
            ch       <= '0;
            cnt_q    <= '{default: '0};
            {s2, s3} <= FS_RED;
            if (state == ST_CLASSIFY) begin
              color       <= result;
              color_valid <= 1'b1;
              have_result <= 1'b1;
              if (!have_result || (result != color)) color_cnt <= 2'd1;
              else if (color_cnt != 2'd3)            color_cnt <= color_cnt + 2'd1;
            end
          end
          ST_SETTLE: timer <= timer_done ? GATE_LD : timer - 1'b1;
          ST_GATE: begin
            if (timer_done) begin
              cnt_q[ch] <= live_cnt;
              timer     <= SETTLE_LD;
              if (ch != 2'd3) begin
                ch       <= ch + 2'd1;
                {s2, s3} <= filter_sel(ch + 2'd1);
              end
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_color_sense.sv
module tb_color_sense;

  localparam int unsigned GATE   = 100;
  localparam int unsigned SETTLE = 10;
  localparam int unsigned CHP    = GATE + SETTLE;
  localparam int unsigned FRAME  = 4 * CHP + 1;
  localparam int unsigned MARGIN = 4;
  localparam int unsigned W_A = 8,  CMIN_A = 20;
  localparam int unsigned W_B = 4,  CMIN_B = 10;

  typedef struct {
    int unsigned color;
    int unsigned cnt;
    int unsigned stamp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, sensor_out;
  logic       s2_o [2];
  logic       s3_o [2];
  logic       valid_o [2];
  logic       busy_o [2];
  logic [1:0] color_o [2];
  logic [1:0] cnt_o [2];

  int unsigned cycle = 0;
  int unsigned checks = 0;
  int unsigned passes = 0;
  exp_t q0[$];
  exp_t q1[$];
  int unsigned held [2];
  int unsigned mcnt [2];
  bit          have [2];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  color_sense #(
    .GATE_CYC(GATE), .SETTLE_CYC(SETTLE), .CNT_W(W_A), .CLEAR_MIN(CMIN_A), .MARGIN(MARGIN)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .sensor_out(sensor_out),
    .s2(s2_o[0]), .s3(s3_o[0]), .color(color_o[0]), .color_valid(valid_o[0]),
    .color_cnt(cnt_o[0]), .busy(busy_o[0])
  );

  color_sense #(
    .GATE_CYC(GATE), .SETTLE_CYC(SETTLE), .CNT_W(W_B), .CLEAR_MIN(CMIN_B), .MARGIN(MARGIN)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .sensor_out(sensor_out),
    .s2(s2_o[1]), .s3(s3_o[1]), .color(color_o[1]), .color_valid(valid_o[1]),
    .color_cnt(cnt_o[1]), .busy(busy_o[1])
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp_v);
    checks++;
    if (act == exp_v) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cycle);
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned w);
    int unsigned top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  // Reference classifier: 1 red, 2 green, 3 blue by index into {r,g,b}
  function automatic int unsigned classify(input int unsigned r, g, b, c, cmin);
    int unsigned v [3];
    int unsigned best, second;
    v[0] = r; v[1] = g; v[2] = b;
    best = 0;
    for (int i = 1; i < 3; i++) if (v[i] > v[best]) best = i;
    second = 0;
    for (int i = 0; i < 3; i++) if (i != best && v[i] > second) second = v[i];
    if (c < cmin) return 0;
    if (v[best] > second && v[best] - second >= MARGIN) return best + 1;
    return 0;
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      held[d] = 0; mcnt[d] = 0; have[d] = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag, input bit after_rst);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_s2s3"}, {s2_o[d], s3_o[d]}, 0);
      check({tag, "_busy"}, busy_o[d], 0);
      check({tag, "_valid"}, valid_o[d], 0);
      if (after_rst) begin
        check({tag, "_color"}, color_o[d], 0);
        check({tag, "_cnt"}, cnt_o[d], 0);
      end
    end
  endtask

  // Called at the negedge preceding the frame's first SETTLE edge.
  // Edge counts are in channel order red, blue, green, clear.
  task automatic run_frame(input int unsigned nr, nb, ng, nc, input bit noise,
                           input int unsigned abort_at, input bit abort_rst);
    bit          wave [0:FRAME];
    int unsigned nch [4];
    int unsigned fs [4];
    int unsigned c0;
    nch[0] = nr; nch[1] = nb; nch[2] = ng; nch[3] = nc;
    fs[0] = 0; fs[1] = 1; fs[2] = 3; fs[3] = 2;
    for (int a = 0; a <= FRAME; a++) wave[a] = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < nch[ch]; k++) wave[CHP * ch + SETTLE + 10 + 2 * k] = 1'b1;
      if (noise) for (int j = 0; j < 4; j++) wave[CHP * ch + 1 + 2 * j] = 1'b1;
    end
    c0 = cycle;
    for (int a = 1; a <= FRAME; a++) begin
      @(negedge clk);
      if (a == abort_at) begin
        sensor_out = 1'b0;
        if (abort_rst) rst = 1'b1;
        else           en  = 1'b0;
        @(negedge clk);
        check_idle(abort_rst ? "rst_abort" : "en_abort", abort_rst);
        if (abort_rst) reset_model();
        repeat (10) @(negedge clk);
        if (abort_rst) rst = 1'b0;
        else           en  = 1'b1;
        return;
      end
      sensor_out = wave[a];
      for (int ch = 0; ch < 4; ch++) begin
        if (a == CHP * ch + 6) begin
          for (int d = 0; d < 2; d++) check("filter_sel", {s2_o[d], s3_o[d]}, fs[ch]);
          if (ch == 1) for (int d = 0; d < 2; d++) check("busy_frame", busy_o[d], 1);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      int unsigned w, cm, res;
      exp_t e;
      w  = (d == 0) ? W_A : W_B;
      cm = (d == 0) ? CMIN_A : CMIN_B;
      res = classify(sat(nr, w), sat(ng, w), sat(nb, w), sat(nc, w), cm);
      if (!have[d] || res != held[d]) mcnt[d] = 1;
      else if (mcnt[d] < 3)           mcnt[d] = mcnt[d] + 1;
      held[d] = res;
      have[d] = 1'b1;
      e.color = res;
      e.cnt   = mcnt[d];
      e.stamp = c0 + FRAME + 1;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (q0.size() != 0 && q0[0].stamp < cycle) begin
      check("a_valid_missing", 0, 1);
      void'(q0.pop_front());
    end
    if (valid_o[0]) begin
      if (q0.size() == 0) check("a_valid_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        check("a_latency", cycle, e.stamp);
        check("a_color", color_o[0], e.color);
        check("a_color_cnt", cnt_o[0], e.cnt);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (q1.size() != 0 && q1[0].stamp < cycle) begin
      check("b_valid_missing", 0, 1);
      void'(q1.pop_front());
    end
    if (valid_o[1]) begin
      if (q1.size() == 0) check("b_valid_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        check("b_latency", cycle, e.stamp);
        check("b_color", color_o[1], e.color);
        check("b_color_cnt", cnt_o[1], e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; sensor_out = 1'b0;
    reset_model();
    repeat (4) @(negedge clk);
    check_idle("reset", 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;

    repeat (4) run_frame(40, 10, 10, 44, 1'b0, 0, 1'b0);
    run_frame(10, 10, 40, 44, 1'b0, 0, 1'b0);
    run_frame(5, 40, 5, 19, 1'b0, 0, 1'b0);
    run_frame(5, 40, 5, 20, 1'b0, 0, 1'b0);
    run_frame(30, 5, 27, 44, 1'b0, 0, 1'b0);
    run_frame(30, 5, 26, 44, 1'b0, 0, 1'b0);
    run_frame(30, 5, 30, 44, 1'b0, 0, 1'b0);
    run_frame(0, 0, 0, 0, 1'b1, 0, 1'b0);
    run_frame(32, 3, 3, 33, 1'b0, 0, 1'b0);

    repeat (6) run_frame($urandom_range(0, 44), $urandom_range(0, 44),
                         $urandom_range(0, 44), $urandom_range(0, 44),
                         1'($urandom_range(0, 1)), 0, 1'b0);

    run_frame(20, 5, 30, 40, 1'b0, 2 * CHP + SETTLE + 51, 1'b0);
    run_frame(5, 5, 30, 40, 1'b0, 0, 1'b0);
    run_frame(30, 5, 5, 40, 1'b0, CHP + SETTLE + 30, 1'b1);
    run_frame(30, 5, 5, 40, 1'b1, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("a_pending", q0.size(), 0);
    check("b_pending", q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
